// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle unsigned ALU. Logic and add-class operations take one
// execute cycle. MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
//
// Handshake: a request is taken at a rising edge where the core is IDLE and
// op_valid is 1. The operands and the operator are latched at that edge. busy is
// high from the next cycle until the DONE cycle. operation_done pulses for the
// single DONE cycle, and result/error are valid from that cycle on. op_valid is
// ignored in every other state and is not queued.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 8,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [OP_W-1:0]  operator,
  input  logic             op_valid,
  output logic             busy,
  output logic             operation_done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_PASS = OP_W'(7);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OP_W-1:0]  op_q;
  // a_q: operand A / multiplicand (shifts left) / dividend-then-quotient.
  // b_q: operand B / multiplier (shifts right) / divisor.
  // acc_q: product accumulator / partial remainder.
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] result_q;
  logic             error_q;

  // Divide-by-zero never iterates. It is resolved in EXEC like the single-cycle ops.
  logic is_iter_op;
  assign is_iter_op = (operator == OP_MUL) ||
                      ((operator == OP_DIV) && (operand_b != '0));

  // One shift-add multiply step.
  logic [WIDTH-1:0] mul_acc_nxt;
  assign mul_acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;

  // One restoring-division step. Bit WIDTH of the difference is the borrow.
  logic [WIDTH:0]   rem_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt  = {a_q[WIDTH-2:0], div_ge};

  // Single-cycle result. In EXEC, DIV can only mean a zero divisor.
  logic [WIDTH-1:0] exec_res;
  logic             exec_err;
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_PASS: exec_res = a_q;
      OP_DIV: begin
        exec_res = '1;
        exec_err = 1'b1;
      end
      default: begin
        exec_res = '0;
        exec_err = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and status decode.
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    operation_done = 1'b0;
    case (state_q)
      IDLE: if (op_valid) state_d = is_iter_op ? ITER : EXEC;
      EXEC: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        operation_done = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, and result/error registers.
  // result/error are written only on the edge that enters DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (op_valid) begin
          a_q   <= operand_a;
          b_q   <= operand_b;
          op_q  <= operator;
          acc_q <= '0;
          if (is_iter_op) cnt_q <= CNT_W'(WIDTH - 1);
        end
        EXEC: begin
          result_q <= exec_res;
          error_q  <= exec_err;
        end
        ITER: begin
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_nxt;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= rem_nxt;
            a_q   <= quo_nxt;
          end
          if (cnt_q == '0) begin
            result_q <= (op_q == OP_MUL) ? mul_acc_nxt : quo_nxt;
            error_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign error     = error_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core. A transaction-level reference model predicts the
// outputs cycle by cycle, and hand-computed directed cases pin that model.
module tb_alu_seq_core;
  localparam int W     = 32;
  localparam int OP_W  = 8;
  localparam int CNT_W = 6;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [W-1:0]    operand_a = '0;
  logic [W-1:0]    operand_b = '0;
  logic [OP_W-1:0] operator = '0;
  logic            op_valid = 1'b0;
  logic            busy, operation_done, error;
  logic [W-1:0]    result;
  logic [1:0]      fsm_state;

  always #5 clock = ~clock;

  alu_seq_core #(.WIDTH(W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .operand_a(operand_a), .operand_b(operand_b), .operator(operator),
    .op_valid(op_valid), .busy(busy), .operation_done(operation_done),
    .result(result), .error(error), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Specification-level meaning of one operation: value, error, latency in cycles.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op,
                        output logic [W-1:0] r, output logic e, output int lat);
    e   = 1'b0;
    lat = 2;
    r   = '0;
    case (op)
      8'd0: r = a + b;
      8'd1: r = a - b;
      8'd2: r = a & b;
      8'd3: r = a | b;
      8'd4: r = a ^ b;
      8'd5: begin r = a * b; lat = W + 1; end
      8'd6: if (b == 0) begin r = '1; e = 1'b1; end
            else begin r = a / b; lat = W + 1; end
      8'd7: r = a;
      default: begin r = '0; e = 1'b1; end
    endcase
  endtask

  // Scoreboard: an accepted request's outcome waits in the queue until its DONE cycle.
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  bit           mdl_active = 1'b0;
  int           mdl_m = 0;     // edges seen since acceptance
  int           mdl_lat = 0;
  logic [W-1:0] mdl_result = '0;
  logic         mdl_error = 1'b0;

  always @(posedge clock or negedge reset) begin
    logic [W-1:0] r;
    logic         e;
    int           lat;
    if (!reset) begin
      mdl_active = 1'b0;
      mdl_m      = 0;
      mdl_result = '0;
      mdl_error  = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
    end else if (mdl_active) begin
      if (mdl_m == mdl_lat - 1) mdl_active = 1'b0;
      else begin
        mdl_m++;
        if (mdl_m == mdl_lat - 1) begin
          mdl_result = exp_q.pop_front();
          mdl_error  = exp_err_q.pop_front();
        end
      end
    end else if (op_valid) begin
      ref_op(operand_a, operand_b, operator, r, e, lat);
      exp_q.push_back(r);
      exp_err_q.push_back(e);
      mdl_lat    = lat;
      mdl_m      = 0;
      mdl_active = 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy",  busy,           mdl_active && (mdl_m < mdl_lat - 1));
      check("cyc_done",  operation_done, mdl_active && (mdl_m == mdl_lat - 1));
      check("cyc_result", result,        mdl_result);
      check("cyc_error", error,          mdl_error);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op,
                        output logic [W-1:0] r, output logic e, output int lat, output int busy_n);
    @(posedge clock); #1;
    operand_a = a; operand_b = b; operator = op; op_valid = 1'b1;
    @(posedge clock); #1;              // acceptance edge just passed
    op_valid  = 1'b0;
    operand_a = $urandom(); operand_b = $urandom(); operator = 8'($urandom_range(0, 7));
    lat = 0; busy_n = 0; r = '0; e = 1'b0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (operation_done) begin
        lat = j + 1;
        r   = result;
        e   = error;
        break;
      end
    end
    check("done_seen", lat != 0, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] r;
    logic         e;
    int           lat, bn, n_done;

    // Pin the model with hand-computed values.
    ref_op(32'd100, 32'd7, 8'd6, r, e, lat);
    check("model_div", {r, e, 8'(lat)}, {32'd14, 1'b0, 8'd33});
    ref_op(32'h0001_0003, 32'h0001_0005, 8'd5, r, e, lat);
    check("model_mul", r, 32'h0008_000F);
    ref_op(32'h5, 32'h0, 8'd6, r, e, lat);
    check("model_div0", {r, e, 8'(lat)}, {32'hFFFF_FFFF, 1'b1, 8'd2});

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy",   busy, 1'b0);
    check("reset_done",   operation_done, 1'b0);
    check("reset_result", result, '0);
    check("reset_error",  error, 1'b0);
    check("reset_state",  fsm_state, 2'd0);
    chk_en = 1'b1;
    reset  = 1'b1;

    // T1 ADD wrap.
    run_op(32'hFFFF_FFFF, 32'd2, 8'd0, r, e, lat, bn);
    check("t1_result", r, 32'd1);
    check("t1_error",  e, 1'b0);
    check("t1_latency", lat, 2);
    // T2 SUB underflow.
    run_op(32'd0, 32'd1, 8'd1, r, e, lat, bn);
    check("t2_result", r, 32'hFFFF_FFFF);
    check("t2_error",  e, 1'b0);
    // T3 MUL.
    run_op(32'h0001_0003, 32'h0001_0005, 8'd5, r, e, lat, bn);
    check("t3_result", r, 32'h0008_000F);
    check("t3_latency", lat, 33);
    check("t3_busy_cycles", bn, 32);
    // T4 DIV and divide by zero.
    run_op(32'd100, 32'd7, 8'd6, r, e, lat, bn);
    check("t4_result", r, 32'd14);
    check("t4_latency", lat, 33);
    run_op(32'd100, 32'd0, 8'd6, r, e, lat, bn);
    check("t4_div0_result", r, 32'hFFFF_FFFF);
    check("t4_div0_error",  e, 1'b1);
    check("t4_div0_latency", lat, 2);
    // Logic ops and pass.
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 8'd4, r, e, lat, bn);
    check("xor_result", r, 32'hFF00_ED34);
    run_op(32'hDEAD_BEEF, 32'h1, 8'd7, r, e, lat, bn);
    check("pass_result", r, 32'hDEAD_BEEF);
    // T5 illegal opcode.
    run_op(32'd9, 32'd9, 8'hA5, r, e, lat, bn);
    check("t5_result", r, 32'd0);
    check("t5_error",  e, 1'b1);
    check("t5_latency", lat, 2);

    // T5 op_valid held high through a MUL: only one completion, with the MUL's value.
    @(posedge clock); #1;
    operand_a = 32'd7; operand_b = 32'd9; operator = 8'd5; op_valid = 1'b1;
    @(posedge clock); #1;
    operand_a = 32'd1; operand_b = 32'd1; operator = 8'd0;   // op_valid stays high
    n_done = 0; lat = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clock);
      if (operation_done) begin
        n_done++; lat = j + 1; r = result;
        op_valid = 1'b0;
        break;
      end
    end
    repeat (40) begin
      @(negedge clock);
      if (operation_done) n_done++;
    end
    check("held_done_count", n_done, 1);
    check("held_result", r, 32'd63);
    check("held_latency", lat, 33);

    // T6 reset in the middle of a DIV.
    run_op(32'd5, 32'd6, 8'd0, r, e, lat, bn);
    check("t6_pre_result", r, 32'd11);
    @(posedge clock); #1;
    operand_a = 32'd100; operand_b = 32'd7; operator = 8'd6; op_valid = 1'b1;
    @(posedge clock); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("t6_busy",   busy, 1'b0);
    check("t6_done",   operation_done, 1'b0);
    check("t6_result", result, '0);
    check("t6_error",  error, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    run_op(32'd3, 32'd4, 8'd0, r, e, lat, bn);
    check("t6_add_result", r, 32'd7);
    check("t6_add_error",  e, 1'b0);

    // Randomized traffic. The per-cycle compare checks it against the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      op_valid  = ($urandom_range(0, 2) == 0);
      operand_a = $urandom();
      case ($urandom_range(0, 9))
        0:       operand_b = '0;
        1, 2:    operand_b = 32'($urandom_range(1, 255));
        default: operand_b = $urandom();
      endcase
      operator = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255))
                                             : 8'($urandom_range(0, 7));
      if (i == 2000) begin
        #2 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
      end
    end
    @(posedge clock); #1 op_valid = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
